// File: rtl/fe_mpa_hit_arbiter.sv
// Readout arbiter for the four MPA hit channels: stamps hits with a BX count,
// buffers them as events and serializes each event as a header plus one word per hit.
module fe_mpa_hit_arbiter #(
    parameter int DEPTH = 8,
    parameter int BX_W  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        hit1_dv,
    input  logic [16:0] hit1_data,
    input  logic        hit2_dv,
    input  logic [16:0] hit2_data,
    input  logic        hit3_dv,
    input  logic [16:0] hit3_data,
    input  logic        hit4_dv,
    input  logic [16:0] hit4_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [21:0] out_data,
    output logic        out_last,
    output logic        fifo_full,
    output logic [15:0] ovf_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [BX_W-1:0]  bx;
        logic [3:0]       mask;
        logic [3:0][16:0] data;
    } event_t;

    typedef enum logic [1:0] {IDLE, HEADER, HITS} state_t;

    state_t          state;
    state_t          state_next;
    logic [BX_W-1:0] bx;
    event_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    event_t          shadow;
    logic [3:0]      remaining;
    logic [3:0]      in_mask;
    event_t          in_event;
    logic            capture;
    logic            push;
    logic            pop;
    logic [1:0]      cur_ch;
    logic            last_hit;
    logic [2:0]      hit_count;

    assign in_mask        = {hit4_dv, hit3_dv, hit2_dv, hit1_dv};
    assign in_event.bx    = bx;
    assign in_event.mask  = in_mask;
    assign in_event.data  = {hit4_data, hit3_data, hit2_data, hit1_data};

    // A full FIFO at the capturing edge drops the event even if IDLE pops that same edge.
    assign capture    = en && (in_mask != 4'b0000);
    assign push       = capture && !fifo_full;
    assign pop        = (state == IDLE) && (count != '0);
    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    assign hit_count = {2'b00, shadow.mask[0]} + {2'b00, shadow.mask[1]}
                     + {2'b00, shadow.mask[2]} + {2'b00, shadow.mask[3]};
    assign last_hit  = (remaining != 4'b0000) && ((remaining & (remaining - 4'd1)) == 4'b0000);

    always_comb begin
        cur_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (remaining[i]) cur_ch = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bx        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            if (en) bx <= bx + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            fifo_full <= (count_next == (AW+1)'(DEPTH));
            if (capture && fifo_full && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_event;
    end

    // The shadow keeps the full event for the header; remaining tracks unsent hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            remaining <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                shadow    <= mem[rd_ptr];
                remaining <= mem[rd_ptr].mask;
            end else if ((state == HITS) && out_ready) begin
                remaining[cur_ch] <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) state_next = HEADER;
            end
            HEADER: begin
                out_valid = 1'b1;
                out_data  = {2'b01, shadow.bx, hit_count, 5'b00000};
                if (out_ready) state_next = HITS;
            end
            HITS: begin
                out_valid = 1'b1;
                out_data  = {2'b10, 1'b0, cur_ch, shadow.data[cur_ch]};
                out_last  = last_hit;
                if (out_ready && last_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
